edge_detector_controller: RTL

- Control FSM that sequences the edge-detector datapath through three phases: image load, Sobel kernel accumulation, result streaming.
- Drives the counter clear/increment strobes, memory write enables and the address-mux select; consumes the datapath's counter-finished flags.
- Faces the Avalon wrapper through a start/done pair, an input valid flag and an output valid/ready handshake.

---
 rtl/edge_detector_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/edge_detector_controller.sv
// Control FSM for the edge-detector datapath: image load, Sobel kernel
// accumulation and result streaming, with a saturating count of processing cycles.
module edge_detector_controller #(
  parameter int CYC_CNT_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     dataAvailable_i,
  input  logic                     outReady_i,
  input  logic                     inputRecieved_i,
  input  logic                     kernelResReady_i,
  input  logic                     imageProcessed_i,
  input  logic                     outputSent_i,
  output logic                     cntrInputClear_o,
  output logic                     cntrKernelClear_o,
  output logic                     cntrMemGclear_o,
  output logic                     memGclear_o,
  output logic                     memImgWr_o,
  output logic                     cntrInputInc_o,
  output logic                     saveImgOrCalculate_o,
  output logic                     cntrKernelInc_o,
  output logic                     memGwr_o,
  output logic                     cntrMemGinc_o,
  output logic                     ready_o,
  output logic                     busy_o,
  output logic                     outValid_o,
  output logic                     done_o,
  output logic [2:0]               Phase_o,
  output logic [CYC_CNT_WIDTH-1:0] CalcCycles_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    CALC  = 3'd3,
    NEXT  = 3'd4,
    OCLR  = 3'd5,
    OUT   = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t                   state;
  logic [CYC_CNT_WIDTH-1:0] calc_cycles;
  logic                     abort_active;

  assign abort_active = abort_i && (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      calc_cycles <= '0;
    end else begin
      if (abort_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:  if (start_i) state <= CLEAR;
          CLEAR: state <= LOAD;
          LOAD:  if (dataAvailable_i && inputRecieved_i) state <= CALC;
          CALC:  if (kernelResReady_i) state <= NEXT;
          NEXT:  state <= imageProcessed_i ? OCLR : CALC;
          OCLR:  state <= OUT;
          OUT:   if (outReady_i && outputSent_i) state <= DONE;
          DONE:  state <= IDLE;
        endcase
      end
      // Counts every cycle spent in CALC/NEXT, sticking at all-ones instead of wrapping.
      if (state == CLEAR) begin
        calc_cycles <= '0;
      end else if ((state == CALC || state == NEXT) && (calc_cycles != '1)) begin
        calc_cycles <= calc_cycles + CYC_CNT_WIDTH'(1);
      end
    end
  end

  // Output handshake: a pixel transfers on a cycle where outValid_o and outReady_i
  // are both high; while outReady_i is low the G counter is not advanced, so the
  // presented pixel stays stable.
  always_comb begin
    cntrInputClear_o     = 1'b0;
    cntrKernelClear_o    = 1'b0;
    cntrMemGclear_o      = 1'b0;
    memGclear_o          = 1'b0;
    memImgWr_o           = 1'b0;
    cntrInputInc_o       = 1'b0;
    saveImgOrCalculate_o = 1'b0;
    cntrKernelInc_o      = 1'b0;
    memGwr_o             = 1'b0;
    cntrMemGinc_o        = 1'b0;
    outValid_o           = 1'b0;
    done_o               = 1'b0;
    case (state)
      CLEAR: begin
        cntrInputClear_o  = 1'b1;
        cntrKernelClear_o = 1'b1;
        cntrMemGclear_o   = 1'b1;
        memGclear_o       = 1'b1;
      end
      LOAD: begin
        memImgWr_o     = dataAvailable_i;
        cntrInputInc_o = dataAvailable_i;
      end
      CALC: begin
        saveImgOrCalculate_o = 1'b1;
        cntrKernelInc_o      = 1'b1;
        memGwr_o             = 1'b1;
      end
      NEXT: begin
        saveImgOrCalculate_o = 1'b1;
        cntrKernelClear_o    = 1'b1;
        cntrMemGinc_o        = 1'b1;
      end
      OCLR: cntrMemGclear_o = 1'b1;
      OUT: begin
        outValid_o    = 1'b1;
        cntrMemGinc_o = outReady_i;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
    // An abort wipes the datapath counters and suppresses all other activity.
    if (abort_active) begin
      cntrInputClear_o     = 1'b1;
      cntrKernelClear_o    = 1'b1;
      cntrMemGclear_o      = 1'b1;
      memGclear_o          = 1'b1;
      memImgWr_o           = 1'b0;
      cntrInputInc_o       = 1'b0;
      saveImgOrCalculate_o = 1'b0;
      cntrKernelInc_o      = 1'b0;
      memGwr_o             = 1'b0;
      cntrMemGinc_o        = 1'b0;
      outValid_o           = 1'b0;
      done_o               = 1'b0;
    end
  end

  assign ready_o      = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign Phase_o      = state;
  assign CalcCycles_o = calc_cycles;

endmodule
